// File: rtl/log2_seq.sv
// log2_seq: unsigned integer -> unsigned fixed-point log2, leading-one detect then one fraction bit per squaring cycle.
// Latency FRAC_W+2 from accept (FRAC_W+4 with LOG2_SEQ_ROUND_EN); in_ready only when idle, result held until out_ready.
module log2_seq #(
   parameter int IN_W    = 8,
   parameter int FRAC_W  = 5,
   parameter int GUARD_W = 4,
   localparam int INT_W  = $clog2(IN_W),
   localparam int OUT_W  = INT_W + FRAC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_zero
);

   localparam int MW = IN_W + GUARD_W;
`ifdef LOG2_SEQ_ROUND_EN
   localparam int NBITS = FRAC_W + 1;
`else
   localparam int NBITS = FRAC_W;
`endif
   localparam int CW = $clog2(NBITS + 1);

   typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_ROUND, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    x_q, x_d;
   logic [INT_W-1:0]   int_q, int_d;
   logic [MW-1:0]      m_q, m_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NBITS-1:0]   bits_q, bits_d;
   logic               zero_q, zero_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_zero_q, out_zero_d;

   logic [INT_W-1:0]   msb;
   logic [INT_W-1:0]   shamt;
   logic [IN_W-1:0]    norm_x;
   logic [2*MW-1:0]    sq;
   logic               sq_lo_unused;

   // Leading-one position of the captured operand; 0 when the operand is 0.
   always_comb begin
      msb = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (x_q[i]) msb = INT_W'(i);
      end
   end

   assign shamt  = INT_W'(IN_W - 1) - msb;
   assign norm_x = x_q << shamt;

   // Q1.x * Q1.x = Q2.2x; the low MW-1 bits are dropped by truncation.
   assign sq           = {{MW{1'b0}}, m_q} * {{MW{1'b0}}, m_q};
   assign sq_lo_unused = ^sq[MW-2:0];

`ifdef LOG2_SEQ_ROUND_EN
   logic [OUT_W:0] rnd_sum;
   assign rnd_sum = {1'b0, int_q, bits_q[NBITS-1:1]} + {{OUT_W{1'b0}}, bits_q[0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_NORM;
         S_NORM:  state_d = S_ITER;
         S_ITER: begin
            if (cnt_q == '0) begin
`ifdef LOG2_SEQ_ROUND_EN
               state_d = S_ROUND;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_ROUND: state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      out_data  = out_data_q;
      out_zero  = out_zero_q;
   end

   always_comb begin
      x_d        = x_q;
      int_d      = int_q;
      m_d        = m_q;
      cnt_d      = cnt_q;
      bits_d     = bits_q;
      zero_d     = zero_q;
      out_data_d = out_data_q;
      out_zero_d = out_zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) x_d = in_data;
         end
         S_NORM: begin
            zero_d = (x_q == '0);
            int_d  = msb;
            m_d    = (x_q == '0) ? '0 : {norm_x, {GUARD_W{1'b0}}};
            cnt_d  = CW'(NBITS);
            bits_d = '0;
         end
         S_ITER: begin
            if (cnt_q != '0) begin
               cnt_d  = cnt_q - CW'(1);
               bits_d = NBITS'({bits_q, sq[2*MW-1]});
               m_d    = sq[2*MW-1] ? sq[2*MW-1:MW] : sq[2*MW-2:MW-1];
            end else begin
`ifndef LOG2_SEQ_ROUND_EN
               out_data_d = zero_q ? '0 : {int_q, bits_q};
               out_zero_d = zero_q;
`endif
            end
         end
`ifdef LOG2_SEQ_ROUND_EN
         // Round half-up on the extra bit; a carry out of OUT_W saturates.
         S_ROUND: begin
            out_data_d = zero_q ? '0 : (rnd_sum[OUT_W] ? '1 : rnd_sum[OUT_W-1:0]);
            out_zero_d = zero_q;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         int_q      <= '0;
         m_q        <= '0;
         cnt_q      <= '0;
         bits_q     <= '0;
         zero_q     <= 1'b0;
         out_data_q <= '0;
         out_zero_q <= 1'b0;
      end else begin
         x_q        <= x_d;
         int_q      <= int_d;
         m_q        <= m_d;
         cnt_q      <= cnt_d;
         bits_q     <= bits_d;
         zero_q     <= zero_d;
         out_data_q <= out_data_d;
         out_zero_q <= out_zero_d;
      end
   end

endmodule

// File: tb/tb_log2_seq.sv
// Bench for log2_seq: directed corner cases plus random operands against an arithmetic log2 model.
// Works for both builds; LOG2_SEQ_ROUND_EN selects the rounded expectations.
module tb_log2_seq;

   localparam int IN_W    = 8;
   localparam int FRAC_W  = 5;
   localparam int GUARD_W = 4;
   localparam int INT_W   = $clog2(IN_W);
   localparam int OUT_W   = INT_W + FRAC_W;
   localparam int MWF     = IN_W - 1 + GUARD_W;
`ifdef LOG2_SEQ_ROUND_EN
   localparam int NB  = FRAC_W + 1;
   localparam int LAT = FRAC_W + 4;
`else
   localparam int NB  = FRAC_W;
   localparam int LAT = FRAC_W + 2;
`endif

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_zero;

   int n_vec = 0;
   int n_err = 0;

   log2_seq #(.IN_W(IN_W), .FRAC_W(FRAC_W), .GUARD_W(GUARD_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_zero(out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // log2 by definition: integer part = floor(log2 x), fraction bits by repeated squaring of x/2^p.
   function automatic int ref_log2(input int x);
      int     p;
      int     frac;
      int     v;
      longint m;
      longint sq;
      if (x == 0) return 0;
      p = 0;
      while ((1 << (p + 1)) <= x) p++;
      m = (longint'(x) << MWF) >> p;
      frac = 0;
      for (int i = 0; i < NB; i++) begin
         sq   = m * m;
         frac = frac * 2;
         if (sq >= (longint'(2) << (2 * MWF))) begin
            frac = frac + 1;
            m    = sq >> (MWF + 1);
         end else begin
            m = sq >> MWF;
         end
      end
`ifdef LOG2_SEQ_ROUND_EN
      v = ((p << (FRAC_W + 1)) + frac + 1) >> 1;
      if (v > (1 << OUT_W) - 1) v = (1 << OUT_W) - 1;
`else
      v = (p << FRAC_W) + frac;
`endif
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present x, wait for acceptance, then count edges until out_valid (bounded).
   task automatic send_op(input logic [IN_W-1:0] x, output int lat, output bit to);
      int w;
      w  = 0;
      to = 1'b0;
      in_data  = x;
      in_valid = 1'b1;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      if (!in_ready) to = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      n_vec++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
   endtask

   task automatic test_zero();
      int lat;
      bit to;
      send_op('0, lat, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL zero_accept timeout=%b exp=0", to); end
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL zero_data got=%h exp=00", out_data); end
      n_vec++; if (out_zero !== 1'b1) begin n_err++; $display("FAIL zero_flag got=%b exp=1", out_zero); end
      take_result();
   endtask

   task automatic test_corners();
      logic [IN_W-1:0]  xs   [5];
      logic [OUT_W-1:0] exps [5];
      int lat;
      bit to;
      xs[0] = 8'd1;   exps[0] = 8'b000_00000;
      xs[1] = 8'd2;   exps[1] = 8'b001_00000;
      xs[2] = 8'd128; exps[2] = 8'b111_00000;
`ifdef LOG2_SEQ_ROUND_EN
      xs[3] = 8'd3;   exps[3] = 8'b001_10011;
`else
      xs[3] = 8'd3;   exps[3] = 8'b001_10010;
`endif
      xs[4] = 8'd255; exps[4] = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         send_op(xs[k], lat, to);
         n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL corner_latency x=%0d got=%0d exp=%0d", xs[k], lat, LAT); end
         n_vec++; if (out_data !== exps[k]) begin n_err++; $display("FAIL corner_data x=%0d got=%b exp=%b", xs[k], out_data, exps[k]); end
         n_vec++; if (out_zero !== 1'b0) begin n_err++; $display("FAIL corner_zero x=%0d got=%b exp=0", xs[k], out_zero); end
         take_result();
      end
   endtask

   task automatic test_backpressure();
      logic [IN_W-1:0]  x;
      logic [OUT_W-1:0] exp_d;
      int lat;
      bit to;
      bit seen;
      x     = IN_W'($urandom_range(1, (1 << IN_W) - 1));
      exp_d = OUT_W'(ref_log2(int'(x)));
      send_op(x, lat, to);
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
      in_valid = 1'b1;
      in_data  = ~x;
      for (int c = 0; c < 5; c++) begin
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, out_valid); end
         n_vec++; if (out_data !== exp_d) begin n_err++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", c, out_data, exp_d); end
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      take_result();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end

      // Abort an operation mid-iteration with a reset pulse.
      in_data  = IN_W'($urandom_range(1, (1 << IN_W) - 1));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL abort_out_data got=%h exp=00", out_data); end
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b exp=0", seen); end
   endtask

   task automatic test_random();
      logic [IN_W-1:0]  x;
      logic [OUT_W-1:0] exp_d;
      int lat;
      int stall;
      bit to;
      for (int k = 0; k < 200; k++) begin
         if (k % 16 == 0) x = IN_W'(1 << $urandom_range(0, IN_W - 1));
         else             x = IN_W'($urandom_range(0, (1 << IN_W) - 1));
         exp_d = OUT_W'(ref_log2(int'(x)));
         send_op(x, lat, to);
         n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL rand_latency x=%0d got=%0d exp=%0d", x, lat, LAT); end
         n_vec++; if (out_data !== exp_d) begin n_err++; $display("FAIL rand_data x=%0d got=%h exp=%h", x, out_data, exp_d); end
         n_vec++; if (out_zero !== (x == '0)) begin n_err++; $display("FAIL rand_zero x=%0d got=%b exp=%b", x, out_zero, (x == '0)); end
         stall = $urandom_range(0, 3);
         repeat (stall) tick();
         n_vec++; if (out_data !== exp_d) begin n_err++; $display("FAIL rand_stall_data x=%0d got=%h exp=%h", x, out_data, exp_d); end
         take_result();
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_corners();
      test_backpressure();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
